// File: rtl/coffee_pkg.sv
// Shared definitions for the coffee_core CPU: opcodes, FSM state encoding and
// instruction field positions.
package coffee_pkg;

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_LOAD   = 8'h01;
  localparam logic [7:0] OP_STORE  = 8'h02;
  localparam logic [7:0] OP_LOADLI = 8'h03;
  localparam logic [7:0] OP_LOADHI = 8'h04;
  localparam logic [7:0] OP_JUMPZ  = 8'h05;
  localparam logic [7:0] OP_MOV    = 8'h06;
  localparam logic [7:0] OP_AND    = 8'h07;
  localparam logic [7:0] OP_OR     = 8'h08;
  localparam logic [7:0] OP_XOR    = 8'h09;
  localparam logic [7:0] OP_ADD    = 8'h0A;
  localparam logic [7:0] OP_HALT   = 8'hFF;

  // Encoding is visible on status[1:0], so it must not change.
  typedef logic [1:0] state_t;
  localparam state_t ST_FETCH = 2'd0;
  localparam state_t ST_EXEC  = 2'd1;
  localparam state_t ST_MEM   = 2'd2;
  localparam state_t ST_HALT  = 2'd3;

  localparam int IR_OP_LSB = 24;
  localparam int IR_A_LSB  = 16;
  localparam int IR_B_LSB  = 8;
  localparam int IR_C_LSB  = 0;

endpackage

// File: rtl/coffee_regfile.sv
// General register file: two combinational read ports, one synchronous write
// port, synchronous clear on reset.
module coffee_regfile #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 8,
  localparam int IDX_W = $clog2(NREGS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IDX_W-1:0]  ra_i,
  input  logic [IDX_W-1:0]  rb_i,
  output logic [DATA_W-1:0] rd_a_o,
  output logic [DATA_W-1:0] rd_b_o,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  wa_i,
  input  logic [DATA_W-1:0] wd_i
);

  logic [DATA_W-1:0] regs_q [NREGS];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  assign rd_a_o = regs_q[ra_i];
  assign rd_b_o = regs_q[rb_i];

endmodule

// File: rtl/coffee_core.sv
// coffee_core: multi-cycle CPU (FETCH/EXEC/MEM/HALT) sharing one instruction/data
// memory over a req/ack port; status exposes FSM state, flags and pc[3:0].
module coffee_core
  import coffee_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 8,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_req,
  output logic              mem_we,
  input  logic              mem_ack,
  output logic              halted,
  output logic [7:0]        status
);

  localparam int IDX_W = $clog2(NREGS);
  localparam logic [DATA_W-1:0] LO_MASK = DATA_W'(32'h0000_FFFF);
  localparam logic [DATA_W-1:0] HI_MASK = DATA_W'(32'hFFFF_0000);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
  logic [31:0]       ir_q, ir_d;
  logic              zero_q, zero_d, ill_q, ill_d;
  logic [7:0]        op;
  logic [15:0]       imm;
  logic [IDX_W-1:0]  fa, fb, fc;
  logic [DATA_W-1:0] rd_a, rd_b, alu;
  logic              rf_we;
  logic [IDX_W-1:0]  rf_wa;
  logic [DATA_W-1:0] rf_wd;
  logic [15:0]       pc_ext;
  logic              unused_bits;

  assign op     = ir_q[IR_OP_LSB +: 8];
  assign imm    = ir_q[15:0];
  assign fa     = ir_q[IR_A_LSB +: IDX_W];
  assign fb     = ir_q[IR_B_LSB +: IDX_W];
  assign fc     = ir_q[IR_C_LSB +: IDX_W];
  assign pc_inc = pc_q + ADDR_W'(1);
  assign pc_ext = 16'(pc_q);
  assign unused_bits = ^{ir_q, pc_ext};

  coffee_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) u_regfile (
    .clk_i  (clk),
    .rst_i  (rst),
    .ra_i   (fa),
    .rb_i   (fb),
    .rd_a_o (rd_a),
    .rd_b_o (rd_b),
    .we_i   (rf_we),
    .wa_i   (rf_wa),
    .wd_i   (rf_wd)
  );

  always_comb begin
    case (op)
      OP_AND:  alu = rd_a & rd_b;
      OP_OR:   alu = rd_a | rd_b;
      OP_XOR:  alu = rd_a ^ rd_b;
      default: alu = rd_a + rd_b;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    zero_d  = zero_q;
    ill_d   = ill_q;
    rf_we   = 1'b0;
    rf_wa   = fa;
    rf_wd   = rd_a;
    unique case (state_q)
      ST_FETCH: begin
        if (mem_ack) begin
          ir_d    = mem_rdata[31:0];
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        pc_d    = pc_inc;
        case (op)
          OP_NOP: ;
          OP_LOAD, OP_STORE: begin
            state_d = ST_MEM;
            pc_d    = pc_q;
          end
          OP_LOADLI: begin
            rf_we = 1'b1;
            rf_wd = (rd_a & ~LO_MASK) | DATA_W'(imm);
          end
          OP_LOADHI: begin
            rf_we = 1'b1;
            rf_wd = (rd_a & ~HI_MASK) | (DATA_W'(imm) << 16);
          end
          OP_JUMPZ: begin
            if (rd_a == '0) pc_d = imm[ADDR_W-1:0];
          end
          OP_MOV: begin
            rf_we  = 1'b1;
            rf_wa  = fb;
            zero_d = (rd_a == '0);
          end
          OP_AND, OP_OR, OP_XOR, OP_ADD: begin
            rf_we  = 1'b1;
            rf_wa  = fc;
            rf_wd  = alu;
            zero_d = (alu == '0);
          end
          OP_HALT: begin
            state_d = ST_HALT;
            pc_d    = pc_q;
          end
          default: ill_d = 1'b1;
        endcase
      end
      ST_MEM: begin
        if (mem_ack) begin
          if (op == OP_LOAD) begin
            rf_we  = 1'b1;
            rf_wd  = mem_rdata;
            zero_d = (mem_rdata == '0);
          end
          pc_d    = pc_inc;
          state_d = ST_FETCH;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      zero_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      zero_q  <= zero_d;
      ill_q   <= ill_d;
    end
  end

  // Handshake: a transfer completes on any clk edge with mem_req && mem_ack.
  // addr/we/wdata come from pc/IR/R[a], which hold until that edge; ack is
  // ignored while req is low, and req is forced low while rst is high.
  assign mem_req   = !rst && ((state_q == ST_FETCH) || (state_q == ST_MEM));
  assign mem_we    = !rst && (state_q == ST_MEM) && (op == OP_STORE);
  assign mem_addr  = (state_q == ST_MEM) ? imm[ADDR_W-1:0] : pc_q;
  assign mem_wdata = rd_a;
  assign halted    = !rst && (state_q == ST_HALT);
  assign status    = {pc_ext[3:0], ill_q, zero_q, state_q};

endmodule

// File: tb/tb_coffee_core.sv
// Bench for coffee_core: wait-state memory model, store scoreboard, fetch log,
// hold checks on the request phase, plus a 64-bit/16-register instance.
module tb_coffee_core;

  localparam int DW   = 32;
  localparam int AW   = 16;
  localparam int SB_W = AW + DW;

  localparam logic [7:0] I_LOAD = 8'h01, I_STORE = 8'h02, I_LOADLI = 8'h03;
  localparam logic [7:0] I_LOADHI = 8'h04, I_JUMPZ = 8'h05, I_MOV = 8'h06;
  localparam logic [7:0] I_AND = 8'h07, I_OR = 8'h08, I_XOR = 8'h09;
  localparam logic [7:0] I_ADD = 8'h0A, I_HALT = 8'hFF;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_req, mem_we, mem_ack, halted;
  logic [7:0]    status;

  coffee_core dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_ack(mem_ack), .halted(halted), .status(status)
  );

  logic [15:0] addr64;
  logic [63:0] wdata64, rdata64;
  logic        req64, we64, ack64, halted64;
  logic [7:0]  status64;

  coffee_core #(.DATA_W(64), .NREGS(16), .ADDR_W(16)) dut64 (
    .clk(clk), .rst(rst), .mem_addr(addr64), .mem_wdata(wdata64),
    .mem_rdata(rdata64), .mem_req(req64), .mem_we(we64),
    .mem_ack(ack64), .halted(halted64), .status(status64)
  );

  // memory models
  logic [31:0] mem [256];
  logic [63:0] mem64 [64];
  int          wait_cycles = 0;
  int          wcnt = 0;
  logic        force_ack = 1'b0;

  assign mem_ack   = (mem_req && (wcnt == wait_cycles)) || force_ack;
  assign mem_rdata = mem[mem_addr[7:0]];
  assign ack64     = req64;
  assign rdata64   = mem64[addr64[5:0]];

  always @(posedge clk) begin
    if (mem_req && mem_we && mem_ack) mem[mem_addr[7:0]] = mem_wdata;
    if (req64 && we64) mem64[addr64[5:0]] = wdata64;
    if (!mem_req || mem_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  // scoreboard
  int n_checks = 0;
  int n_fail = 0;
  logic [SB_W-1:0] exp_q[$];
  logic [AW-1:0]   fetch_log[$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  logic          pend = 1'b0;
  logic [AW-1:0] hold_addr;
  logic          hold_we;
  logic [DW-1:0] hold_wdata;
  logic [SB_W-1:0] sb_exp;

  always @(negedge clk) begin
    if (mem_req && mem_ack && !mem_we && status[1:0] == 2'd0) fetch_log.push_back(mem_addr);
    if (mem_req && mem_ack && mem_we) begin
      if (exp_q.size() > 0) sb_exp = exp_q.pop_front();
      else sb_exp = '1;
      check("store", 64'({mem_addr, mem_wdata}), 64'(sb_exp));
    end
    if (pend && mem_req) begin
      check("hold_addr", 64'(mem_addr), 64'(hold_addr));
      check("hold_we", 64'(mem_we), 64'(hold_we));
      check("hold_wdata", 64'(mem_wdata), 64'(hold_wdata));
    end
    pend       = mem_req && !mem_ack;
    hold_addr  = mem_addr;
    hold_we    = mem_we;
    hold_wdata = mem_wdata;
  end

  // driver tasks
  int pa;
  int exp_cyc;

  function automatic logic [31:0] i3(input logic [7:0] op, a, b, c);
    return {op, a, b, c};
  endfunction

  function automatic logic [31:0] ii(input logic [7:0] op, a, input logic [15:0] imm);
    return {op, a, imm};
  endfunction

  task automatic emit(input logic [31:0] w);
    mem[pa[7:0]] = w;
    pa++;
    if (w[31:24] == I_LOAD || w[31:24] == I_STORE) exp_cyc += 2 * wait_cycles + 3;
    else exp_cyc += wait_cycles + 2;
  endtask

  task automatic expect_store(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic assert_rst();
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_req", 64'(mem_req), 64'(0));
    check("rst_halted", 64'(halted), 64'(0));
    @(posedge clk);
    #1 check("rst_status", 64'(status), 64'(0));
  endtask

  task automatic begin_test(input int w);
    assert_rst();
    wait_cycles = w;
    for (int i = 0; i < 256; i++) mem[i] = {I_HALT, 24'h0};
    pa = 0;
    exp_cyc = 0;
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1 rst = 1'b0;
    fetch_log.delete();
  endtask

  task automatic run(input int budget, output int n);
    n = 0;
    while (!halted && n < budget) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check("halt_reached", 64'(halted), 64'(1));
  endtask

  int n;

  initial begin
    for (int i = 0; i < 64; i++) mem64[i] = 64'(ii(I_HALT, 0, 0));
    mem64[0]    = 64'(ii(I_LOAD, 9, 16'h0020));
    mem64[1]    = 64'(ii(I_LOADHI, 9, 16'hABCD));
    mem64[2]    = 64'(ii(I_STORE, 9, 16'h0021));
    mem64[3]    = 64'(i3(I_MOV, 9, 12, 0));
    mem64[4]    = 64'(ii(I_STORE, 12, 16'h0022));
    mem64[5]    = 64'(ii(I_HALT, 0, 0));
    mem64[6'h20] = 64'hDEADBEEF_5555_7777;

    // LOADLI/LOADHI then HALT, zero-wait
    begin_test(0);
    emit(ii(I_LOADLI, 1, 16'h0005));
    emit(ii(I_LOADHI, 1, 16'h0001));
    emit(ii(I_HALT, 0, 0));
    release_rst();
    run(200, n);
    check("a_cycles", 64'(n), 64'(exp_cyc));
    check("a_pc", 64'(status[7:4]), 64'(2));
    check("a_state", 64'(status[1:0]), 64'(3));

    // ADD wraps, zero flag clear
    begin_test(1);
    emit(ii(I_LOADLI, 1, 16'hFFFF));
    emit(ii(I_LOADHI, 1, 16'hFFFF));
    emit(ii(I_LOADLI, 2, 16'h0002));
    emit(i3(I_ADD, 1, 2, 3));
    emit(ii(I_STORE, 3, 16'h0030));
    emit(ii(I_HALT, 0, 0));
    expect_store(16'h0030, 32'h0000_0001);
    release_rst();
    run(200, n);
    check("b1_cycles", 64'(n), 64'(exp_cyc));
    check("b1_zero", 64'(status[2]), 64'(0));
    check("b1_drain", 64'(exp_q.size()), 64'(0));

    // AND/OR/MOV into R0, then XOR to zero
    begin_test(0);
    emit(ii(I_LOADLI, 1, 16'hFFFF));
    emit(ii(I_LOADHI, 1, 16'hFFFF));
    emit(ii(I_LOADLI, 2, 16'h0002));
    emit(i3(I_ADD, 1, 2, 3));
    emit(ii(I_STORE, 3, 16'h0030));
    emit(i3(I_AND, 1, 2, 6));
    emit(i3(I_OR, 3, 2, 7));
    emit(i3(I_MOV, 7, 0, 0));
    emit(ii(I_STORE, 6, 16'h0031));
    emit(ii(I_STORE, 0, 16'h0032));
    emit(i3(I_XOR, 3, 3, 4));
    emit(ii(I_STORE, 4, 16'h0033));
    emit(ii(I_HALT, 0, 0));
    expect_store(16'h0030, 32'h0000_0001);
    expect_store(16'h0031, 32'h0000_0002);
    expect_store(16'h0032, 32'h0000_0003);
    expect_store(16'h0033, 32'h0000_0000);
    release_rst();
    run(300, n);
    check("b2_cycles", 64'(n), 64'(exp_cyc));
    check("b2_zero", 64'(status[2]), 64'(1));
    check("b2_drain", 64'(exp_q.size()), 64'(0));

    // STORE / LOAD through 3 wait states
    begin_test(3);
    mem[8'h40] = 32'hDEAD_0040;
    emit(ii(I_LOADLI, 1, 16'h0005));
    emit(ii(I_LOADHI, 1, 16'h0001));
    emit(ii(I_STORE, 1, 16'h0040));
    emit(ii(I_LOAD, 5, 16'h0040));
    emit(ii(I_STORE, 5, 16'h0041));
    emit(ii(I_HALT, 0, 0));
    expect_store(16'h0040, 32'h0001_0005);
    expect_store(16'h0041, 32'h0001_0005);
    release_rst();
    run(300, n);
    check("c_cycles", 64'(n), 64'(exp_cyc));
    check("c_mem40", 64'(mem[8'h40]), 64'(32'h0001_0005));
    check("c_drain", 64'(exp_q.size()), 64'(0));

    // JUMPZ taken on R0, not taken on R1
    begin_test(0);
    emit(ii(I_LOADLI, 1, 16'h0005));
    emit(ii(I_JUMPZ, 0, 16'h0010));
    mem[8'h10] = ii(I_JUMPZ, 1, 16'h0020);
    mem[8'h11] = ii(I_HALT, 0, 0);
    release_rst();
    run(200, n);
    check("d_nfetch", 64'(fetch_log.size()), 64'(4));
    if (fetch_log.size() == 4) begin
      check("d_fetch2", 64'(fetch_log[2]), 64'(16'h0010));
      check("d_fetch3", 64'(fetch_log[3]), 64'(16'h0011));
    end
    check("d_pc", 64'(status[7:4]), 64'(1));

    // illegal opcode acts as NOP, sticky flag
    begin_test(2);
    emit(ii(I_LOADLI, 1, 16'h0009));
    emit(32'h4201_0101);
    emit(ii(I_STORE, 1, 16'h0050));
    emit(ii(I_HALT, 0, 0));
    expect_store(16'h0050, 32'h0000_0009);
    release_rst();
    run(200, n);
    check("e_cycles", 64'(n), 64'(exp_cyc));
    check("e_illegal", 64'(status[3]), 64'(1));
    check("e_pc", 64'(status[7:4]), 64'(3));
    repeat (5) @(negedge clk);
    check("e_sticky", 64'(status[3]), 64'(1));
    check("e_drain", 64'(exp_q.size()), 64'(0));

    // reset during the wait of a STORE, with a stray ack
    begin_test(3);
    mem[8'h40] = 32'hDEAD_0040;
    emit(ii(I_LOADLI, 1, 16'h0007));
    emit(ii(I_STORE, 1, 16'h0040));
    emit(ii(I_HALT, 0, 0));
    release_rst();
    n = 0;
    while (status[1:0] != 2'd2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("f_in_mem", 64'(status[1:0]), 64'(2));
    @(posedge clk);
    #1 rst = 1'b1;
    force_ack = 1'b1;
    #1;
    check("f_rst_req", 64'(mem_req), 64'(0));
    check("f_rst_halted", 64'(halted), 64'(0));
    mem[0] = ii(I_STORE, 1, 16'h0041);
    mem[1] = ii(I_HALT, 0, 0);
    expect_store(16'h0041, 32'h0000_0000);
    @(posedge clk);
    #1 force_ack = 1'b0;
    check("f_rst_status", 64'(status), 64'(0));
    rst = 1'b0;
    fetch_log.delete();
    run(200, n);
    check("f_first_fetch", 64'(fetch_log.size() > 0 ? fetch_log[0] : '1), 64'(0));
    check("f_mem40", 64'(mem[8'h40]), 64'(32'hDEAD_0040));
    check("f_pc", 64'(status[7:4]), 64'(1));
    check("f_drain", 64'(exp_q.size()), 64'(0));

    // 64-bit, 16-register instance
    repeat (30) @(negedge clk);
    check("w64_halted", 64'(halted64), 64'(1));
    check("w64_state", 64'(status64[1:0]), 64'(3));
    check("w64_loadhi", mem64[6'h21], 64'hDEADBEEF_ABCD_7777);
    check("w64_mov", mem64[6'h22], 64'hDEADBEEF_ABCD_7777);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
